instr_fetch: RTL and testbench

//  Multicycle fetch stage directly upstream of register_file: owns PC, OldPC and the instruction register (IR).

---
 rtl/riscv_pkg.sv | 17 +
 rtl/instr_fetch.sv | 106 ++++++++++
 tb/tb_instr_fetch.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: data width, the canonical NOP encoding and
// the fetch-stage state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Multicycle instruction fetch stage: owns PC, OldPC and IR.
// One word read per instruction over a valid/ready memory port. The fetched
// word sits in IR until the controller pulses advance with the next PC.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN
//   defined   -> a misaligned pc_next traps into a sticky FAULT state
//   undefined -> pc_next is silently word-aligned, fetch_fault tied low
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            advance,
  input  logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic            fetch_fault
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] old_pc_q;
  logic [XLEN-1:0] ir_q;
  logic            ivld_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic            fault_q;
`endif

  // Fetch FSM plus PC / OldPC / IR / valid state; each state only listens to
  // the one input that is legal for it, so stray rsp/advance pulses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc_q     <= RESET_PC;
      old_pc_q <= RESET_PC;
      ir_q     <= NOP_INSTR;
      ivld_q   <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        FETCH: begin
          if (mem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            ir_q     <= mem_rdata;
            old_pc_q <= pc_q;
            ivld_q   <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (advance) begin
            ivld_q <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            // Keep the offending target visible on pc for the trap handler.
            pc_q <= pc_next;
            if (pc_next[1:0] != 2'b00) begin
              fault_q <= 1'b1;
              ir_q    <= NOP_INSTR;
              state   <= FAULT;
            end else begin
              state   <= FETCH;
            end
`else
            pc_q  <= pc_next & ~32'h3;
            state <= FETCH;
`endif
          end
        end
        default: begin
          // FAULT is terminal until reset.
          state <= state;
        end
      endcase
    end
  end

  // Moore outputs; the request is also gated by reset so nothing is issued
  // while rst_n is held low.
  always_comb begin
    mem_req_valid = rst_n && (state == FETCH);
    mem_addr      = pc_q;
    instr         = ir_q;
    instr_valid   = ivld_q;
    pc            = pc_q;
    old_pc        = old_pc_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
    fetch_fault   = fault_q;
`else
    fetch_fault   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a randomized memory responder pushes the expected
// {word, address} of every accepted request into a scoreboard queue; a
// separate monitor pops and compares each time a new instruction appears.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        advance = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] old_pc;
  logic        fetch_fault;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .advance(advance), .pc_next(pc_next),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .old_pc(old_pc),
    .fetch_fault(fetch_fault)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: address the next fetch must use.
  logic [31:0] m_pc = RESET_PC;

  // Responder knobs
  int ready_prob = 0;
  int lat_min = 0;
  int lat_max = 0;
  int spur_prob = 0;
  bit stale_rsp = 0;
  bit pend = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory responder: random ready, random response latency, stray responses
  // while nothing is outstanding.
  initial begin : mem_model
    int lat;
    logic [31:0] rsp_data;
    lat = 0;
    rsp_data = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        exp_q.delete();
        m_pc = RESET_PC;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rdata = $urandom;
        if (pend) begin
          if (lat == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rdata = rsp_data;
            pend = 0;
          end else begin
            lat--;
          end
        end else if (stale_rsp || ($urandom_range(99) < spur_prob)) begin
          mem_rsp_valid = 1'b1;
          stale_rsp = 0;
        end
        mem_req_ready = ($urandom_range(99) < ready_prob);
        if (mem_req_valid && mem_req_ready && !pend) begin
          chk("req_addr", mem_addr, m_pc);
          rsp_data = mem_word(m_pc);
          exp_q.push_back('{data: rsp_data, addr: m_pc});
          pend = 1;
          lat = $urandom_range(lat_max, lat_min);
        end
      end
    end
  end

  // Monitor: each new instruction must match the oldest outstanding fetch and
  // stay stable while it is held.
  initial begin : monitor
    bit prev_v;
    logic [31:0] last_instr;
    exp_t e;
    prev_v = 0;
    last_instr = NOP;
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: instr %h appeared with no outstanding fetch", instr);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr", instr, e.data);
          chk("sb_old_pc", old_pc, e.addr);
          chk("sb_pc", pc, e.addr);
          last_instr = e.data;
        end
      end else if (rst_n && instr_valid) begin
        chk("hold_stable", instr, last_instr);
      end
      prev_v = rst_n && instr_valid;
    end
  end

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) begin
      checks++;
      failures++;
      $display("FAIL wait_valid: instr_valid still %b after %0d cycles, need 1", instr_valid, n);
    end
  endtask

  task automatic do_advance(logic [31:0] v);
    wait_valid();
    advance = 1'b1;
    pc_next = v;
    m_pc = v & 32'hFFFF_FFFC;
    @(negedge clk);
    advance = 1'b0;
    pc_next = $urandom;
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_req_valid"}, {31'b0, mem_req_valid}, 32'd0);
    chk({tag, "_instr"}, instr, NOP);
    chk({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_pc"}, pc, RESET_PC);
    chk({tag, "_old_pc"}, old_pc, RESET_PC);
    chk({tag, "_fault"}, {31'b0, fetch_fault}, 32'd0);
  endtask

  initial begin : main
    logic [31:0] r;
    logic [31:0] v;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_state("rst");

    // First fetch: always ready, single-cycle response
    ready_prob = 100;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("first_req_valid", {31'b0, mem_req_valid}, 32'd1);
    chk("first_addr", mem_addr, RESET_PC);
    repeat (2) @(negedge clk);
    chk("first_valid_c3", {31'b0, instr_valid}, 32'd1);
    chk("first_instr_c3", instr, 32'h0050_0093);
    chk("first_old_pc_c3", old_pc, 32'h0);

    // Jump to 0x40 with memory stalled; stray advance while fetching
    ready_prob = 0;
    do_advance(32'h0000_0040);
    chk("adv_pc", pc, 32'h40);
    chk("adv_valid_drop", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("stall_req_valid", {31'b0, mem_req_valid}, 32'd1);
      chk("stall_addr", mem_addr, 32'h40);
      advance = (i == 1);
      pc_next = 32'h0000_1234;
      @(negedge clk);
    end
    advance = 1'b0;
    chk("stray_adv_pc", pc, 32'h40);
    chk("stall_valid_low", {31'b0, instr_valid}, 32'd0);
    ready_prob = 100;
    wait_valid();

    // Reset while a response is outstanding
    lat_min = 3;
    lat_max = 3;
    do_advance(32'h0000_0080);
    for (int i = 0; i < 20 && !pend; i++) @(negedge clk);
    chk("mid_wait_reached", {31'b0, pend}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("midwait_rst");
    ready_prob = 0;
    lat_min = 0;
    lat_max = 2;
    @(posedge clk);
    #2 rst_n = 1'b1;
    stale_rsp = 1;
    repeat (3) @(negedge clk);
    chk("stale_instr", instr, NOP);
    chk("stale_valid", {31'b0, instr_valid}, 32'd0);
    chk("refetch_addr", mem_addr, RESET_PC);
    chk("refetch_req", {31'b0, mem_req_valid}, 32'd1);
    ready_prob = 100;
    wait_valid();

    // Randomized traffic
    ready_prob = 60;
    lat_max = 3;
    spur_prob = 20;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (instr_valid && $urandom_range(99) < 40) begin
        r = $urandom;
`ifdef IFETCH_MISALIGN_TRAP_EN
        v = (($urandom_range(9) == 0) ? 32'hFFFF_FFFC : {r[31:2], 2'b00});
`else
        v = (($urandom_range(9) == 0) ? 32'hFFFF_FFFE : r);
`endif
        advance = 1'b1;
        pc_next = v;
        m_pc = v & 32'hFFFF_FFFC;
      end else if (!instr_valid && $urandom_range(99) < 20) begin
        advance = 1'b1;
        pc_next = $urandom;
      end else begin
        advance = 1'b0;
      end
    end
    advance = 1'b0;
    @(negedge clk);
    wait_valid();
    chk("drain_empty", exp_q.size(), 32'd0);

    // Misaligned target
    spur_prob = 0;
    ready_prob = 100;
    do_advance(32'h0000_0042);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("trap_fault", {31'b0, fetch_fault}, 32'd1);
    chk("trap_pc", pc, 32'h42);
    for (int i = 0; i < 5; i++) begin
      chk("trap_no_req", {31'b0, mem_req_valid}, 32'd0);
      chk("trap_valid", {31'b0, instr_valid}, 32'd0);
      chk("trap_instr", instr, NOP);
      @(negedge clk);
    end
    chk("trap_sticky", {31'b0, fetch_fault}, 32'd1);
`else
    chk("mask_pc", pc, 32'h40);
    chk("mask_addr", mem_addr, 32'h40);
    chk("mask_fault", {31'b0, fetch_fault}, 32'd0);
    wait_valid();
    chk("mask_old_pc", old_pc, 32'h40);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
